// File: rtl/dmem_responder.sv
// Doubleword data-memory target with valid/ready request and response
// channels, a fixed response latency and a held response register.
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic [63:0]   mem [DEPTH];
  logic [63:0]   off;
  logic [IW-1:0] idx;
  logic          err;
  logic          accept;

  // Wrapped offset; below-base addresses are caught by the compare.
  assign off = req_addr - BASE_ADDR;
  assign idx = off[IW+2:3];
  assign err = (off[2:0] != 3'd0)
             || (req_addr < BASE_ADDR)
             || (|off[63:IW+3]);

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready && rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rsp_err   <= err;
        rsp_rdata <= (err || req_we) ? '0 : mem[idx];
      end
    end
  end

  // Storage is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 8; i++) begin
        if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: a LATENCY=2 instance at base 0 and
// a LATENCY=1 instance at base 0x1000, both checked against a byte-mask model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [63:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl [2][16];

  dmem_responder #(
    .DEPTH(1024), .LATENCY(2), .BASE_ADDR(64'h0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(
    .DEPTH(16), .LATENCY(1), .BASE_ADDR(64'h1000)
  ) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] base_of(input int s);
    return (s == 0) ? 64'h0 : 64'h1000;
  endfunction

  function automatic logic [63:0] depth_of(input int s);
    return (s == 0) ? 64'd1024 : 64'd16;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  function automatic bit is_err(input int s, input logic [63:0] a);
    return (a % 8 != 0) || (a < base_of(s))
        || ((a - base_of(s)) / 8 >= depth_of(s));
  endfunction

  function automatic int slot(input int s, input logic [63:0] a);
    return int'((a - base_of(s)) / 8);
  endfunction

  // Called and returns at a negedge.
  task automatic do_txn(input int s, input bit we, input logic [63:0] a,
                        input logic [63:0] wd, input logic [7:0] ws,
                        input int stall, input bit keep,
                        output logic [63:0] got);
    logic [63:0] exp_d;
    logic [63:0] mask;
    bit          e;
    int          n;
    e     = is_err(s, a);
    exp_d = (e || we) ? 64'h0 : mdl[s][slot(s, a)];
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = a;
    req_wdata[s] = wd;
    req_wstrb[s] = ws;
    rsp_ready[s] = (stall == 0);
    got = 64'h0;
    n = 0;
    while (!req_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[s]) begin
      check("accept_timeout", 64'(req_ready[s]), 64'd1);
      req_valid[s] = 1'b0;
      return;
    end
    @(posedge clk);
    if (we && !e) begin
      mask = 64'h0;
      for (int i = 0; i < 8; i++)
        if (ws[i]) mask = mask | (64'hFF << (8 * i));
      mdl[s][slot(s, a)] = (mdl[s][slot(s, a)] & ~mask) | (wd & mask);
    end
    @(negedge clk);
    if (!keep) req_valid[s] = 1'b0;
    check("busy_ready", 64'(req_ready[s]), 64'd0);
    n = 1;
    while (!rsp_valid[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(lat_of(s)));
    check("rdata", rsp_rdata[s], exp_d);
    check("err", 64'(rsp_err[s]), 64'(e));
    got = rsp_rdata[s];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid[s]), 64'd1);
      check("hold_rdata", rsp_rdata[s], exp_d);
      check("hold_err", 64'(rsp_err[s]), 64'(e));
      check("hold_ready", 64'(req_ready[s]), 64'd0);
    end
    rsp_ready[s] = 1'b1;
    @(negedge clk);
    check("done_valid", 64'(rsp_valid[s]), 64'd0);
    check("done_ready", 64'(req_ready[s]), 64'd1);
    rsp_ready[s] = 1'b0;
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] prior;
    logic [63:0] a;
    int          r;
    int          ix;
    int          st;

    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_addr[s]  = 64'h0;
      req_wdata[s] = 64'h0;
      req_wstrb[s] = 8'h0;
      rsp_ready[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 64'(req_ready[s]), 64'd1);
      check("rst_valid", 64'(rsp_valid[s]), 64'd0);
      check("rst_rdata", rsp_rdata[s], 64'h0);
      check("rst_err", 64'(rsp_err[s]), 64'd0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_valid0", 64'(rsp_valid[0]), 64'd0);
      check("idle_valid1", 64'(rsp_valid[1]), 64'd0);
    end

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        do_txn(s, 1'b1, base_of(s) + 64'(i * 8),
               {$urandom, $urandom}, 8'hFF, 0, 1'b0, got);

    do_txn(0, 1'b1, 64'h18, 64'h1122334455667788, 8'hFF, 0, 1'b0, got);
    do_txn(0, 1'b0, 64'h18, 64'h0, 8'h0, 0, 1'b0, got);
    check("roundtrip", got, 64'h1122334455667788);
    do_txn(0, 1'b1, 64'h18, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 1'b0, got);
    do_txn(0, 1'b0, 64'h18, 64'h0, 8'h0, 0, 1'b0, got);
    check("partial", got, 64'h11223344AAAAAAAA);

    do_txn(0, 1'b0, 64'h1C, 64'h0, 8'h0, 0, 1'b0, got);
    prior = mdl[0][0];
    do_txn(0, 1'b1, 64'h2000, 64'hDEADBEEFDEADBEEF, 8'hFF, 1, 1'b0, got);
    do_txn(0, 1'b0, 64'h0, 64'h0, 8'h0, 0, 1'b0, got);
    check("err_store_nowrite", got, prior);

    do_txn(0, 1'b0, 64'h18, 64'h0, 8'h0, 5, 1'b1, got);
    do_txn(0, 1'b0, 64'h18, 64'h0, 8'h0, 0, 1'b0, got);
    check("held_req", got, 64'h11223344AAAAAAAA);

    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 64'h40;
    req_wdata[0] = 64'h0123456789ABCDEF;
    req_wstrb[0] = 8'hFF;
    @(posedge clk);
    mdl[0][8] = 64'h0123456789ABCDEF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("wait_ready", 64'(req_ready[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_ready", 64'(req_ready[0]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_valid", 64'(rsp_valid[0]), 64'd0);
    end
    do_txn(0, 1'b0, 64'h40, 64'h0, 8'h0, 0, 1'b0, got);
    check("midrst_commit", got, 64'h0123456789ABCDEF);

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 80; k++) begin
        r  = $urandom_range(0, 9);
        ix = $urandom_range(0, 15);
        a  = base_of(s) + 64'(ix * 8);
        if (r == 0) a = a + 64'($urandom_range(1, 7));
        if (r == 1) a = base_of(s) + depth_of(s) * 8 + 64'(ix * 8);
        if (r == 2)
          a = (s == 0) ? 64'hFFFFFFFFFFFFFFF8
                       : base_of(s) - 64'((ix + 1) * 8);
        st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        do_txn(s, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
               8'($urandom_range(0, 255)), st, 1'b0, got);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
